// File: rtl/memory_responder.sv
// Memory-side responder: word-addressed RAM plus a small I/O window (switches,
// LEDs, free-running timer, output FIFO with a valid/ready drain port).
module memory_responder #(
  parameter int unsigned ADDR_BITS  = 10,
  parameter logic [15:0] IO_BASE    = 16'hFFF0,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic [15:0] Mem_Addr,
  input  logic        Mem_Write,
  input  logic [15:0] Data_In,
  output logic [15:0] Mem_Data,
  input  logic [7:0]  Switches,
  output logic [7:0]  Leds,
  output logic [15:0] Out_Data,
  output logic        Out_Valid,
  input  logic        Out_Ready
);

  localparam int unsigned RAM_WORDS = 2 ** ADDR_BITS;
  localparam int unsigned PTR_W     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W     = $clog2(FIFO_DEPTH + 1);

  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(FIFO_DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(FIFO_DEPTH - 1);

  localparam logic [3:0] OFF_SWITCH = 4'd0;
  localparam logic [3:0] OFF_LED    = 4'd1;
  localparam logic [3:0] OFF_TIMER  = 4'd2;
  localparam logic [3:0] OFF_PUSH   = 4'd3;
  localparam logic [3:0] OFF_STATUS = 4'd4;

  logic [15:0]          ram_mem [RAM_WORDS];
  logic [15:0]          fifo_q  [FIFO_DEPTH];

  logic [15:0]          mem_data_q, mem_data_d;
  logic [7:0]           sw_meta_q, sw_sync_q;
  logic [7:0]           leds_q, leds_d;
  logic [15:0]          timer_q, timer_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic                 ovf_q, ovf_d;
  logic [15:0]          out_data_q, out_data_d;
  logic                 out_valid_q, out_valid_d;

  logic                 io_sel_c, ram_sel_c;
  logic [3:0]           offset_c;
  logic [ADDR_BITS-1:0] ram_idx_c;
  logic                 led_wr_c, timer_wr_c, push_req_c, status_wr_c;
  logic                 pop_c, push_ok_c;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : PTR_W'(p + 1'b1);
  endfunction

  // Address decode and I/O write strobes
  always_comb begin
    io_sel_c    = (Mem_Addr[15:4] == IO_BASE[15:4]);
    ram_sel_c   = !io_sel_c && (Mem_Addr[15:ADDR_BITS] == '0);
    offset_c    = Mem_Addr[3:0];
    ram_idx_c   = Mem_Addr[ADDR_BITS-1:0];
    led_wr_c    = Mem_Write && io_sel_c && (offset_c == OFF_LED);
    timer_wr_c  = Mem_Write && io_sel_c && (offset_c == OFF_TIMER);
    push_req_c  = Mem_Write && io_sel_c && (offset_c == OFF_PUSH);
    status_wr_c = Mem_Write && io_sel_c && (offset_c == OFF_STATUS);
  end

  // Read mux uses pre-write state, which gives read-first behaviour
  always_comb begin
    mem_data_d = '0;
    if (ram_sel_c) begin
      mem_data_d = ram_mem[ram_idx_c];
    end else if (io_sel_c) begin
      case (offset_c)
        OFF_SWITCH: mem_data_d = {8'h00, sw_sync_q};
        OFF_LED:    mem_data_d = {8'h00, leds_q};
        OFF_TIMER:  mem_data_d = timer_q;
        OFF_STATUS: mem_data_d = {ovf_q, 11'b0, 4'(count_q)};
        default:    mem_data_d = '0;
      endcase
    end
  end

  always_comb begin
    leds_d  = led_wr_c ? Data_In[7:0] : leds_q;
    timer_d = timer_wr_c ? Data_In : 16'(timer_q + 16'd1);
  end

  // FIFO control: a full FIFO still accepts a push when it pops the same cycle
  always_comb begin
    pop_c     = (count_q != '0) && Out_Ready;
    push_ok_c = push_req_c && ((count_q != DEPTH_C) || pop_c);
    rd_ptr_d  = pop_c ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    wr_ptr_d  = push_ok_c ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    count_d   = count_q;
    case ({push_ok_c, pop_c})
      2'b10:   count_d = CNT_W'(count_q + 1'b1);
      2'b01:   count_d = CNT_W'(count_q - 1'b1);
      default: count_d = count_q;
    endcase
    ovf_d = ovf_q;
    if (status_wr_c) begin
      ovf_d = 1'b0;
    end else if (push_req_c && !push_ok_c) begin
      ovf_d = 1'b1;
    end
    out_valid_d = (count_d != '0);
    out_data_d  = (push_ok_c && (wr_ptr_q == rd_ptr_d)) ? Data_In : fifo_q[rd_ptr_d];
  end

  always_ff @(posedge Clock) begin
    if (Mem_Write && ram_sel_c) begin
      ram_mem[ram_idx_c] <= Data_In;
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      mem_data_q  <= '0;
      sw_meta_q   <= '0;
      sw_sync_q   <= '0;
      leds_q      <= '0;
      timer_q     <= '0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      ovf_q       <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        fifo_q[i] <= '0;
      end
    end else begin
      mem_data_q  <= mem_data_d;
      sw_meta_q   <= Switches;
      sw_sync_q   <= sw_meta_q;
      leds_q      <= leds_d;
      timer_q     <= timer_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      ovf_q       <= ovf_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      if (push_ok_c) begin
        fifo_q[wr_ptr_q] <= Data_In;
      end
    end
  end

  assign Mem_Data  = mem_data_q;
  assign Leds      = leds_q;
  assign Out_Data  = out_data_q;
  assign Out_Valid = out_valid_q;

endmodule

// File: tb/tb_memory_responder.sv
// Bench for memory_responder: directed scenarios plus random traffic, checked
// against a queue/array reference model of the memory map.
module tb_memory_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] mem_addr;
  logic        mem_write;
  logic [15:0] data_in;
  logic [15:0] mem_data;
  logic [7:0]  switches;
  logic [7:0]  leds;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic [15:0] m_ram [1024];
  logic [7:0]  m_leds;
  logic [15:0] m_timer;
  logic [15:0] m_q[$];
  logic        m_ovf;
  logic [7:0]  m_s1, m_s2;
  logic [15:0] m_mem_data;

  always #5 clk = ~clk;

  memory_responder dut (
    .Clock     (clk),
    .Reset     (rst_n),
    .Mem_Addr  (mem_addr),
    .Mem_Write (mem_write),
    .Data_In   (data_in),
    .Mem_Data  (mem_data),
    .Switches  (switches),
    .Leds      (leds),
    .Out_Data  (out_data),
    .Out_Valid (out_valid),
    .Out_Ready (out_ready)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] model_read(input logic [15:0] a);
    if (a[15:4] == 12'hFFF) begin
      case (a[3:0])
        4'd0:    return {8'h00, m_s2};
        4'd1:    return {8'h00, m_leds};
        4'd2:    return m_timer;
        4'd4:    return {m_ovf, 11'b0, 4'(m_q.size())};
        default: return 16'h0000;
      endcase
    end
    if (a < 16'd1024) return m_ram[a[9:0]];
    return 16'h0000;
  endfunction

  task automatic model_reset();
    m_leds = '0; m_timer = '0; m_q.delete(); m_ovf = 1'b0;
    m_s1 = '0; m_s2 = '0; m_mem_data = '0;
  endtask

  // One clock cycle: drive inputs, advance the model at the edge, compare after it
  task automatic step(input logic [15:0] a, input logic wr, input logic [15:0] d,
                      input logic rdy, input bit chk_md = 1'b1);
    mem_addr = a; mem_write = wr; data_in = d; out_ready = rdy;
    @(posedge clk);
    m_mem_data = model_read(a);
    m_s2 = m_s1;
    m_s1 = switches;
    if (wr && a[15:4] == 12'hFFF && a[3:0] == 4'd2) m_timer = d;
    else m_timer = m_timer + 16'd1;
    if (rdy && m_q.size() != 0) void'(m_q.pop_front());
    if (wr) begin
      if (a[15:4] == 12'hFFF) begin
        case (a[3:0])
          4'd1: m_leds = d[7:0];
          4'd3: if (m_q.size() < 4) m_q.push_back(d); else m_ovf = 1'b1;
          4'd4: m_ovf = 1'b0;
          default: ;
        endcase
      end else if (a < 16'd1024) begin
        m_ram[a[9:0]] = d;
      end
    end
    #1;
    if (chk_md) chk("mem_data", mem_data, m_mem_data);
    chk("leds", {8'h00, leds}, {8'h00, m_leds});
    chk("out_valid", {15'h0, out_valid}, {15'h0, m_q.size() != 0});
    if (m_q.size() != 0) chk("out_data", out_data, m_q[0]);
  endtask

  initial begin
    logic [15:0] a;
    rst_n = 1'b0; mem_addr = '0; mem_write = 1'b0; data_in = '0;
    switches = '0; out_ready = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    chk("rst_mem_data", mem_data, 16'h0000);
    chk("rst_leds", {8'h00, leds}, 16'h0000);
    chk("rst_out_valid", {15'h0, out_valid}, 16'h0000);
    chk("rst_out_data", out_data, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 1024; i++) step(16'(i), 1'b1, 16'h0000, 1'b0, 1'b0);

    // RAM readback and unmapped read
    step(16'h0005, 1'b1, 16'hBEEF, 1'b0);
    step(16'h0005, 1'b0, 16'h0000, 1'b0);
    chk("ram_beef", mem_data, 16'hBEEF);
    step(16'h0400, 1'b1, 16'h1234, 1'b0);
    step(16'h0400, 1'b0, 16'h0000, 1'b0);
    chk("unmapped", mem_data, 16'h0000);

    // Read-first
    step(16'h0005, 1'b1, 16'h1111, 1'b0);
    step(16'h0005, 1'b1, 16'h2222, 1'b0);
    chk("read_first_old", mem_data, 16'h1111);
    step(16'h0005, 1'b0, 16'h0000, 1'b0);
    chk("read_first_new", mem_data, 16'h2222);

    // I/O registers
    step(16'hFFF1, 1'b1, 16'h00A5, 1'b0);
    chk("leds_a5", {8'h00, leds}, 16'h00A5);
    switches = 8'h3C;
    repeat (3) step(16'hFFF0, 1'b0, 16'h0000, 1'b0);
    chk("switches", mem_data, 16'h003C);
    step(16'hFFF2, 1'b1, 16'hFFFE, 1'b0);
    step(16'hFFF2, 1'b0, 16'h0000, 1'b0);
    chk("timer0", mem_data, 16'hFFFE);
    step(16'hFFF2, 1'b0, 16'h0000, 1'b0);
    chk("timer1", mem_data, 16'hFFFF);
    step(16'hFFF2, 1'b0, 16'h0000, 1'b0);
    chk("timer_wrap", mem_data, 16'h0000);

    // FIFO fill, overflow, drain, ovf clear
    for (int v = 1; v <= 5; v++) step(16'hFFF3, 1'b1, 16'(v), 1'b0);
    step(16'hFFF4, 1'b0, 16'h0000, 1'b0);
    chk("status_ovf", mem_data, 16'h8004);
    for (int v = 1; v <= 4; v++) begin
      chk("drain_valid", {15'h0, out_valid}, 16'h0001);
      chk("drain_data", out_data, 16'(v));
      step(16'h0000, 1'b0, 16'h0000, 1'b1);
    end
    chk("drain_empty", {15'h0, out_valid}, 16'h0000);
    step(16'hFFF4, 1'b1, 16'h0000, 1'b0);
    step(16'hFFF4, 1'b0, 16'h0000, 1'b0);
    chk("status_clear", mem_data, 16'h0000);

    // Full FIFO with simultaneous pop and push
    for (int v = 5; v <= 8; v++) step(16'hFFF3, 1'b1, 16'(v), 1'b0);
    step(16'hFFF3, 1'b1, 16'h0009, 1'b1);
    step(16'hFFF4, 1'b0, 16'h0000, 1'b0);
    chk("full_pushpop", mem_data, 16'h0004);
    for (int v = 6; v <= 9; v++) begin
      chk("pp_drain", out_data, 16'(v));
      step(16'h0000, 1'b0, 16'h0000, 1'b1);
    end
    chk("pp_empty", {15'h0, out_valid}, 16'h0000);

    // Asynchronous reset mid-operation
    step(16'hFFF3, 1'b1, 16'h00AA, 1'b0);
    step(16'hFFF3, 1'b1, 16'h00BB, 1'b0);
    step(16'hFFF1, 1'b1, 16'h00FF, 1'b0);
    step(16'hFFF2, 1'b0, 16'h0000, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("async_out_valid", {15'h0, out_valid}, 16'h0000);
    chk("async_leds", {8'h00, leds}, 16'h0000);
    chk("async_mem_data", mem_data, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    step(16'h0005, 1'b0, 16'h0000, 1'b0);
    chk("ram_kept", mem_data, 16'h2222);
    step(16'hFFF2, 1'b0, 16'h0000, 1'b0);

    // Random traffic against the model
    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 3))
        0:       a = 16'($urandom_range(0, 1023));
        1:       a = 16'hFFF0 | 16'($urandom_range(0, 15));
        2:       a = 16'($urandom_range(16'h0400, 16'hFFEF));
        default: a = 16'hFFF3;
      endcase
      if ($urandom_range(0, 7) == 0) switches = 8'($urandom);
      step(a, 1'($urandom_range(0, 1)), 16'($urandom), 1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
